// File: rtl/imm_ext_ctrl.sv
// imm_ext_ctrl: decode-stage controller for the dual-lane sign extender of the
// 2-wide RISC-V front end. Assembles the raw immediate of each slot from the
// instruction encoding, drives the extender lanes, captures the extended
// result plus valid/illegal flags into an elastic output stage, and hands
// pairs to rename/dispatch with a pair-level valid/ready handshake.
//
// Ports:
//   clk, rst_n (sync, active-low), flush   - clock, reset, pipeline flush
//   in_valid[1:0], in_instr[1:0], in_ready - fetch-queue side (slot 0 older)
//   ext_in, ext_op_code, ext_en, ext_type  - extender request lanes
//   ext_imm[1:0]                           - extender result (combinational)
//   out_valid, out_imm, out_illegal        - head pair to rename/dispatch
//   out_ready                              - consumer accepts the head pair
//
// Configuration macro IMM_EXT_SKID_EN:
//   defined   - two pair entries (head + skid), registered in_ready
//   undefined - single pair entry, in_ready combinational from out_ready
module imm_ext_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [1:0]           in_valid,
    input  logic [1:0][XLEN-1:0] in_instr,
    output logic                 in_ready,
    output logic [1:0][XLEN-1:0] ext_in,
    output logic [1:0][4:0]      ext_op_code,
    output logic [1:0]           ext_en,
    output logic [1:0]           ext_type,
    input  logic [1:0][XLEN-1:0] ext_imm,
    output logic [1:0]           out_valid,
    output logic [1:0][XLEN-1:0] out_imm,
    output logic [1:0]           out_illegal,
    input  logic                 out_ready
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // Raw immediate handed to the extender; I-type and B-type are left
    // zero-padded so the extender performs their sign extension.
    function automatic logic [XLEN-1:0] assemble(input logic [XLEN-1:0] instr);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (instr[6:2])
            OPC_LOAD, OPC_OPIMM: imm = {20'd0, instr[31:20]};
            OPC_JALR:            imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:           imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:          imm = {19'd0, instr[31], instr[7], instr[30:25],
                                        instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:  imm = {instr[31:12], 12'd0};
            OPC_JAL:             imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                        instr[20], instr[30:21], 1'b0};
            default:             imm = '0;
        endcase
        return imm;
    endfunction

    // Opcodes that carry an immediate the extender must process.
    function automatic logic has_imm(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE,
            OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Opcodes belonging to the RV32I base set.
    function automatic logic is_base(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_FENCE, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    logic [1:0][XLEN-1:0] cap_imm;
    logic [1:0]           cap_illegal;
    logic [1:0]           head_valid;
    logic [1:0]           head_illegal;
    logic [1:0][XLEN-1:0] head_imm;
    logic                 in_xfer;
    logic                 out_xfer;

    // Extender request lanes.
    always_comb begin
        ext_in      = '0;
        ext_op_code = '0;
        ext_en      = '0;
        ext_type    = '0;
        for (int i = 0; i < 2; i++) begin
            ext_op_code[i] = in_instr[i][6:2];
            ext_in[i]      = assemble(in_instr[i]);
            ext_en[i]      = in_valid[i] && has_imm(in_instr[i][6:2]);
        end
    end

    // Capture payload; kept apart from the request lanes since ext_imm
    // returns through the extender within the same cycle.
    always_comb begin
        cap_imm     = '0;
        cap_illegal = '0;
        for (int i = 0; i < 2; i++) begin
            cap_imm[i]     = in_valid[i] ? ext_imm[i] : '0;
            cap_illegal[i] = in_valid[i] &&
                             (!is_base(in_instr[i][6:2]) || (in_instr[i][1:0] != 2'b11));
        end
    end

    assign in_xfer     = (|in_valid) && in_ready;
    assign out_xfer    = (|head_valid) && out_ready;
    assign out_valid   = head_valid;
    assign out_imm     = head_imm;
    assign out_illegal = head_illegal;

`ifdef IMM_EXT_SKID_EN

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t               state;
    logic [1:0]           skid_valid;
    logic [1:0]           skid_illegal;
    logic [1:0][XLEN-1:0] skid_imm;
    logic                 ready_q;

    assign in_ready = ready_q;

    // Two-entry output stage: head drives out_*, skid absorbs one pair of backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state        <= EMPTY;
            head_valid   <= '0;
            head_illegal <= '0;
            head_imm     <= '0;
            skid_valid   <= '0;
            skid_illegal <= '0;
            skid_imm     <= '0;
            ready_q      <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        head_valid   <= in_valid;
                        head_illegal <= cap_illegal;
                        head_imm     <= cap_imm;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_valid   <= in_valid;
                        skid_illegal <= cap_illegal;
                        skid_imm     <= cap_imm;
                        ready_q      <= 1'b0;
                        state        <= TWO;
                    end else if (in_xfer) begin
                        head_valid   <= in_valid;
                        head_illegal <= cap_illegal;
                        head_imm     <= cap_imm;
                    end else if (out_xfer) begin
                        head_valid   <= '0;
                        head_illegal <= '0;
                        head_imm     <= '0;
                        state        <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        head_valid   <= skid_valid;
                        head_illegal <= skid_illegal;
                        head_imm     <= skid_imm;
                        skid_valid   <= '0;
                        skid_illegal <= '0;
                        skid_imm     <= '0;
                        ready_q      <= 1'b1;
                        state        <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`else

    typedef enum logic {EMPTY, ONE} state_t;

    state_t state;

    // Single entry: a new pair may enter only as the current head leaves.
    assign in_ready = !(|head_valid) || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state        <= EMPTY;
            head_valid   <= '0;
            head_illegal <= '0;
            head_imm     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        head_valid   <= in_valid;
                        head_illegal <= cap_illegal;
                        head_imm     <= cap_imm;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer) begin
                        head_valid   <= in_valid;
                        head_illegal <= cap_illegal;
                        head_imm     <= cap_imm;
                    end else if (out_xfer) begin
                        head_valid   <= '0;
                        head_illegal <= '0;
                        head_imm     <= '0;
                        state        <= EMPTY;
                    end
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Testbench for imm_ext_ctrl: directed and random pairs, a behavioural
// extender on the ext_* lanes, and a scoreboard of expected output pairs.
module tb_imm_ext_ctrl;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [1:0]        in_valid;
    logic [1:0][31:0]  in_instr;
    logic              in_ready;
    logic [1:0][31:0]  ext_in;
    logic [1:0][4:0]   ext_op_code;
    logic [1:0]        ext_en;
    logic [1:0]        ext_type;
    logic [1:0][31:0]  ext_imm;
    logic [1:0]        out_valid;
    logic [1:0][31:0]  out_imm;
    logic [1:0]        out_illegal;
    logic              out_ready;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  ill;
        logic [31:0] imm0;
        logic [31:0] imm1;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    logic checking;

    imm_ext_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .ext_in(ext_in), .ext_op_code(ext_op_code), .ext_en(ext_en),
        .ext_type(ext_type), .ext_imm(ext_imm),
        .out_valid(out_valid), .out_imm(out_imm), .out_illegal(out_illegal),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural extender: signed type sign-extends I (12-bit) and B (13-bit)
    // fields, unsigned type passes through; disabled lanes pass ext_in through.
    always_comb begin
        ext_imm = '0;
        for (int i = 0; i < 2; i++) begin
            ext_imm[i] = ext_in[i];
            if (ext_en[i] && !ext_type[i]) begin
                if (ext_op_code[i] == 5'b00000 || ext_op_code[i] == 5'b00100)
                    ext_imm[i] = {{20{ext_in[i][11]}}, ext_in[i][11:0]};
                else if (ext_op_code[i] == 5'b11000)
                    ext_imm[i] = {{19{ext_in[i][12]}}, ext_in[i][12:0]};
            end
        end
    end

    // Architectural immediate value of an instruction, via signed arithmetic.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        int r;
        r = 0;
        case (w[6:2])
            5'b00000, 5'b00100, 5'b11001: begin i12 = w[31:20]; r = int'(i12); end
            5'b01000: begin i12 = {w[31:25], w[11:7]}; r = int'(i12); end
            5'b11000: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r = int'(b13); end
            5'b01101, 5'b00101: r = int'({w[31:12], 12'h000});
            5'b11011: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r = int'(j21); end
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic ref_has_imm(input logic [31:0] w);
        case (w[6:2])
            5'b00000, 5'b00100, 5'b11001, 5'b01000,
            5'b11000, 5'b01101, 5'b00101, 5'b11011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] w);
        logic base;
        case (w[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: base = 1'b1;
            default: base = 1'b0;
        endcase
        return !base || (w[1:0] != 2'b11);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [4:0]  op;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: op = 5'b00000;
            1: op = 5'b00011;
            2: op = 5'b00100;
            3: op = 5'b00101;
            4: op = 5'b01000;
            5: op = 5'b01100;
            6: op = 5'b01101;
            7: op = 5'b11000;
            8: op = 5'b11001;
            9: op = 5'b11011;
            10: op = 5'b11100;
            default: op = 5'($urandom_range(0, 31));
        endcase
        w[6:2] = op;
        if ($urandom_range(0, 9) != 0) w[1:0] = 2'b11;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one cycle of stimulus and record the expected pair if it transfers.
    task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic ordy, input logic fl);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid    = v;
        in_instr[0] = i0;
        in_instr[1] = i1;
        out_ready   = ordy;
        flush       = fl;
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("ext_en", 32'(ext_en[i]), 32'(v[i] && ref_has_imm(in_instr[i])));
            check("ext_op_code", 32'(ext_op_code[i]), 32'(in_instr[i][6:2]));
            check("ext_type", 32'(ext_type[i]), 32'd0);
        end
        if (fl) begin
            q.delete();
        end else if (v != 2'b00 && in_ready) begin
            e.v    = v;
            e.ill  = {v[1] && ref_illegal(i1), v[0] && ref_illegal(i0)};
            e.imm0 = v[0] ? ref_imm(i0) : 32'd0;
            e.imm1 = v[1] ? ref_imm(i1) : 32'd0;
            q.push_back(e);
        end
    endtask

    // Monitor: every cycle compare the head pair and in_ready with the scoreboard.
    logic [1:0] exp_v;
    logic       exp_rdy;
    exp_t       popped;
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                exp_v = (q.size() == 0) ? 2'b00 : q[0].v;
                check("out_valid", 32'(out_valid), 32'(exp_v));
`ifdef IMM_EXT_SKID_EN
                exp_rdy = (q.size() < 2);
`else
                exp_rdy = (q.size() == 0) || out_ready;
`endif
                check("in_ready", 32'(in_ready), 32'(exp_rdy));
                if (q.size() != 0) begin
                    check("out_imm0", out_imm[0], q[0].imm0);
                    check("out_imm1", out_imm[1], q[0].imm1);
                    check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
                    if (out_ready && !flush) popped = q.pop_front();
                end
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        checking = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 2'b00;
        in_instr = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        check("rst_imm0", out_imm[0], 32'd0);
        check("rst_imm1", out_imm[1], 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);

        // addi -1 / lui 0x80000
        step(2'b11, 32'hFFF00093, 32'h80000537, 1'b1, 1'b0);
        // beq -4 / sw -8
        step(2'b11, 32'hFE000EE3, 32'hFE112C23, 1'b1, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure, then drain in order.
        step(2'b11, rand_instr(), rand_instr(), 1'b0, 1'b0);
        step(2'b11, rand_instr(), rand_instr(), 1'b0, 1'b0);
        step(2'b11, rand_instr(), rand_instr(), 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

        // Partial pair with an illegal encoding in slot 1; slot 0 invalid.
        step(2'b10, 32'hFFF00093, 32'h00000000, 1'b1, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a full buffer.
        step(2'b11, rand_instr(), rand_instr(), 1'b0, 1'b0);
        step(2'b11, rand_instr(), rand_instr(), 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        repeat (2) step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            step(2'($urandom_range(0, 3)), rand_instr(), rand_instr(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        repeat (6) step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drained", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
